// File: rtl/lcd_stream_capture.sv
// lcd_stream_capture: captures the LCD dual-pixel RGB stream into memory
// as an AHB-lite master, one pixel per word {8'h00,R,G,B}, even/odd words.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   cfg_start            one-cycle arm pulse (ignored while out_busy)
//   cfg_base_addr        byte address of word 0 (8-byte aligned)
//   cfg_data_count       dual pixels to capture (0 = none)
//   in_valid, in_r0..b1  incoming dual-pixel beat
//   out_H*, in_HREADY,
//   in_HRESP             AHB-lite master port (SINGLE word writes)
//   out_busy             armed or transfers outstanding
//   out_done             one-cycle completion pulse
//   out_overflow         sticky: beat dropped on full FIFO
//   out_err              sticky: ERROR response seen
module lcd_stream_capture #(
    parameter int          W_ADDR       = 32,
    parameter int          W_DATA       = 32,
    parameter int          IMG_PIX_W    = 8,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          W_FRAME_SIZE = 25,
    // {cacheable=0, bufferable=0, privileged=0, data=1}
    parameter logic [3:0]  DEF_HPROT    = 4'b0001
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cfg_start,
    input  logic [W_ADDR-1:0]       cfg_base_addr,
    input  logic [W_FRAME_SIZE-1:0] cfg_data_count,
    input  logic                    in_valid,
    input  logic [IMG_PIX_W-1:0]    in_r0,
    input  logic [IMG_PIX_W-1:0]    in_g0,
    input  logic [IMG_PIX_W-1:0]    in_b0,
    input  logic [IMG_PIX_W-1:0]    in_r1,
    input  logic [IMG_PIX_W-1:0]    in_g1,
    input  logic [IMG_PIX_W-1:0]    in_b1,
    output logic [1:0]              out_HTRANS,
    output logic [W_ADDR-1:0]       out_HADDR,
    output logic                    out_HWRITE,
    output logic [2:0]              out_HSIZE,
    output logic [2:0]              out_HBURST,
    output logic [3:0]              out_HPROT,
    output logic [W_DATA-1:0]       out_HWDATA,
    input  logic                    in_HREADY,
    input  logic [1:0]              in_HRESP,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_overflow,
    output logic                    out_err
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 3 * IMG_PIX_W;
    localparam int EW = 2 * PW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W0,
        ST_W1
    } state_t;

    state_t                  state_q, state_d;
    logic [W_ADDR-1:0]       addr_q, addr_d;
    logic [W_FRAME_SIZE-1:0] rem_q, rem_d;
    logic [W_FRAME_SIZE-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;
    logic                    err_q, err_d;
    logic                    dph_q, dph_d;
    logic                    dlast_q, dlast_d;
    logic [W_DATA-1:0]       wdata_q, wdata_d;
    logic [AW:0]             wr_q, wr_d;
    logic [AW:0]             rd_q, rd_d;

    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [EW-1:0]           head;
    logic [AW:0]             count;
    logic                    empty, full;
    logic                    push, pop, flush, err_hit;

    assign head  = mem[rd_q[AW-1:0]];
    assign count = wr_q - rd_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));

    assign err_hit = dph_q && (in_HRESP == RESP_ERROR);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        dph_d   = dph_q;
        dlast_d = dlast_q;
        wdata_d = wdata_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;

        // Bus side: every transition waits for an accepted cycle.
        if (in_HREADY) begin
            if (dph_q && dlast_q) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            dph_d   = 1'b0;
            dlast_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) state_d = ST_W0;
                end
                ST_W0: begin
                    state_d = ST_W1;
                    wdata_d = W_DATA'(head[EW-1:PW]);
                    dph_d   = 1'b1;
                end
                ST_W1: begin
                    pop     = 1'b1;
                    wdata_d = W_DATA'(head[PW-1:0]);
                    addr_d  = addr_q + W_ADDR'(8);
                    rem_d   = rem_q - W_FRAME_SIZE'(1);
                    dph_d   = 1'b1;
                    dlast_d = (rem_q == W_FRAME_SIZE'(1));
                    // Go straight on only if another entry is already queued.
                    if (rem_q != W_FRAME_SIZE'(1) && count > (AW+1)'(1))
                        state_d = ST_W0;
                    else
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Stream side: a pop in the same cycle frees a slot on a full FIFO.
        if (in_valid && acc_q != '0) begin
            acc_d = acc_q - W_FRAME_SIZE'(1);
            if (!full || pop)
                push = 1'b1;
            else
                ovf_d = 1'b1;
        end

        if (cfg_start && !busy_q) begin
            addr_d = cfg_base_addr;
            rem_d  = cfg_data_count;
            acc_d  = cfg_data_count;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
            busy_d = (cfg_data_count != '0);
            done_d = (cfg_data_count == '0);
        end

        // ERROR abandons the frame; the data phase lasts until HREADY.
        if (err_hit) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
            rem_d   = '0;
            acc_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
            dph_d   = !in_HREADY;
            dlast_d = 1'b0;
            wdata_d = wdata_q;
            push    = 1'b0;
            pop     = 1'b0;
            flush   = 1'b1;
        end

        wr_d = flush ? '0 : wr_q + (AW+1)'(push);
        rd_d = flush ? '0 : rd_q + (AW+1)'(pop);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            dph_q   <= 1'b0;
            dlast_q <= 1'b0;
            wdata_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            dph_q   <= dph_d;
            dlast_q <= dlast_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push)
            mem[wr_q[AW-1:0]] <= {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1};
    end

    assign out_HTRANS   = (state_q == ST_IDLE) ? TRANS_IDLE : TRANS_NONSEQ;
    assign out_HADDR    = (state_q == ST_W1) ? addr_q + W_ADDR'(4) : addr_q;
    assign out_HWRITE   = (state_q != ST_IDLE);
    assign out_HSIZE    = SIZE_WORD;
    assign out_HBURST   = BURST_SINGLE;
    assign out_HPROT    = DEF_HPROT;
    assign out_HWDATA   = wdata_q;
    assign out_busy     = busy_q;
    assign out_done     = done_q;
    assign out_overflow = ovf_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_lcd_stream_capture.sv
// tb_lcd_stream_capture: directed bench for lcd_stream_capture.
// Records completed AHB writes and checks them against hand-computed values.
module tb_lcd_stream_capture;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [24:0] cfg_data_count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_r0 = '0, in_g0 = '0, in_b0 = '0;
    logic [7:0]  in_r1 = '0, in_g1 = '0, in_b1 = '0;
    logic [1:0]  out_HTRANS;
    logic [31:0] out_HADDR;
    logic        out_HWRITE;
    logic [2:0]  out_HSIZE;
    logic [2:0]  out_HBURST;
    logic [3:0]  out_HPROT;
    logic [31:0] out_HWDATA;
    logic        in_HREADY = 1'b1;
    logic [1:0]  in_HRESP = 2'b00;
    logic        out_busy, out_done, out_overflow, out_err;

    int npass = 0;
    int ntot  = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic        pend;
    logic [31:0] pend_addr;

    lcd_stream_capture dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_data_count (cfg_data_count),
        .in_valid       (in_valid),
        .in_r0          (in_r0),
        .in_g0          (in_g0),
        .in_b0          (in_b0),
        .in_r1          (in_r1),
        .in_g1          (in_g1),
        .in_b1          (in_b1),
        .out_HTRANS     (out_HTRANS),
        .out_HADDR      (out_HADDR),
        .out_HWRITE     (out_HWRITE),
        .out_HSIZE      (out_HSIZE),
        .out_HBURST     (out_HBURST),
        .out_HPROT      (out_HPROT),
        .out_HWDATA     (out_HWDATA),
        .in_HREADY      (in_HREADY),
        .in_HRESP       (in_HRESP),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_overflow   (out_overflow),
        .out_err        (out_err)
    );

    always #5 HCLK = ~HCLK;

    // AHB slave view: an address phase accepted on one edge completes its
    // data phase on the next edge with HREADY high.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (in_HREADY) begin
            if (pend) begin
                wr_addr.push_back(pend_addr);
                wr_data.push_back(out_HWDATA);
            end
            pend      <= (out_HTRANS == 2'b10) && out_HWRITE;
            pend_addr <= out_HADDR;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic beat(input logic [7:0] b);
        in_valid = 1'b1;
        in_r0 = b;
        in_g0 = b + 8'd1;
        in_b0 = b + 8'd2;
        in_r1 = b + 8'd3;
        in_g1 = b + 8'd4;
        in_b1 = b + 8'd5;
    endtask

    task automatic start(input logic [31:0] base, input logic [24:0] n);
        cfg_start      = 1'b1;
        cfg_base_addr  = base;
        cfg_data_count = n;
        cyc(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cyc(1);
            if (out_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] ga(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bit seen;
        bit dseen;
        int prev;

        // Reset values
        #1;
        chk("rst_htrans", 32'(out_HTRANS), 32'h0);
        chk("rst_hsize", 32'(out_HSIZE), 32'h2);
        chk("rst_hburst", 32'(out_HBURST), 32'h0);
        chk("rst_hprot", 32'(out_HPROT), 32'h1);
        chk("rst_haddr", out_HADDR, 32'h0);
        chk("rst_hwdata", out_HWDATA, 32'h0);
        chk("rst_flags", {28'h0, out_busy, out_done, out_overflow, out_err},
            32'h0);
        cyc(2);
        HRESETn = 1'b1;
        cyc(1);

        // Basic frame, zero wait states
        wr_addr.delete(); wr_data.delete();
        start(32'h1000, 25'd4);
        chk("t1_busy", 32'(out_busy), 32'h1);
        beat(8'h10); cyc(1);
        chk("t1_lat_idle", 32'(out_HTRANS), 32'h0);
        beat(8'h20); cyc(1);
        chk("t1_lat_nonseq", 32'(out_HTRANS), 32'h2);
        chk("t1_first_addr", out_HADDR, 32'h1000);
        beat(8'h30); cyc(1);
        beat(8'h40); cyc(1);
        in_valid = 1'b0;
        seen = 1'b0;
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            prev = wr_addr.size();
            cyc(1);
            if (out_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_done", 32'(seen), 32'h1);
        chk("t1_done_timing", 32'(prev), 32'd7);
        chk("t1_nwrites", 32'(wr_addr.size()), 32'd8);
        chk("t1_busy_end", 32'(out_busy), 32'h0);
        for (int i = 0; i < 8; i++)
            chk("t1_addr", ga(i), 32'h1000 + 32'(4 * i));
        chk("t1_d0", gd(0), 32'h0010_1112);
        chk("t1_d1", gd(1), 32'h0013_1415);
        chk("t1_d4", gd(4), 32'h0030_3132);
        chk("t1_d7", gd(7), 32'h0043_4445);
        cyc(1);
        chk("t1_done_pulse", 32'(out_done), 32'h0);

        // Wait states during the 0x1004 address phase
        wr_addr.delete(); wr_data.delete();
        start(32'h1000, 25'd1);
        beat(8'hA0); cyc(1);
        in_valid = 1'b0;
        cyc(1);
        chk("t2_w0_addr", out_HADDR, 32'h1000);
        cyc(1);
        chk("t2_w1_addr", out_HADDR, 32'h1004);
        in_HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t2_hold_addr", out_HADDR, 32'h1004);
            chk("t2_hold_trans", 32'(out_HTRANS), 32'h2);
            chk("t2_hold_data", out_HWDATA, 32'h00A0_A1A2);
        end
        in_HREADY = 1'b1;
        cyc(1);
        chk("t2_d1_data", out_HWDATA, 32'h00A3_A4A5);
        wait_done(10, seen);
        chk("t2_done", 32'(seen), 32'h1);
        chk("t2_nwrites", 32'(wr_addr.size()), 32'd2);
        chk("t2_wd0", gd(0), 32'h00A0_A1A2);
        chk("t2_wd1", gd(1), 32'h00A3_A4A5);

        // Overflow: 20 beats while the bus is stalled
        wr_addr.delete(); wr_data.delete();
        start(32'h3000, 25'd20);
        in_HREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(8'(i)); cyc(1);
        end
        in_valid = 1'b0;
        cyc(20);
        chk("t3_overflow", 32'(out_overflow), 32'h1);
        chk("t3_busy_stall", 32'(out_busy), 32'h1);
        chk("t3_no_writes", 32'(wr_addr.size()), 32'd0);
        in_HREADY = 1'b1;
        dseen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (out_done) dseen = 1'b1;
        end
        chk("t3_nwrites", 32'(wr_addr.size()), 32'd32);
        chk("t3_last_addr", ga(31), 32'h307C);
        chk("t3_busy_after", 32'(out_busy), 32'h1);
        chk("t3_no_done", 32'(dseen), 32'h0);
        chk("t3_idle", 32'(out_HTRANS), 32'h0);
        HRESETn = 1'b0;
        #1;
        chk("t3_rst_flags", {30'h0, out_busy, out_overflow}, 32'h0);
        cyc(1);
        HRESETn = 1'b1;
        cyc(1);

        // Reset mid-frame, then restart at 0x2000
        start(32'h5000, 25'd4);
        for (int i = 0; i < 4; i++) begin
            beat(8'h50 + 8'(i)); cyc(1);
        end
        in_valid = 1'b0;
        chk("t6_active", 32'(out_HTRANS), 32'h2);
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_trans", 32'(out_HTRANS), 32'h0);
        chk("t6_rst_addr", out_HADDR, 32'h0);
        chk("t6_rst_wdata", out_HWDATA, 32'h0);
        chk("t6_rst_flags", {29'h0, out_HWRITE, out_busy, out_done}, 32'h0);
        cyc(1);
        HRESETn = 1'b1;
        cyc(1);
        wr_addr.delete(); wr_data.delete();
        start(32'h2000, 25'd2);
        beat(8'h60); cyc(1);
        beat(8'h70); cyc(1);
        in_valid = 1'b0;
        wait_done(30, seen);
        chk("t6_done", 32'(seen), 32'h1);
        chk("t6_nwrites", 32'(wr_addr.size()), 32'd4);
        chk("t6_a0", ga(0), 32'h2000);
        chk("t6_a3", ga(3), 32'h200C);
        chk("t6_d2", gd(2), 32'h0070_7172);

        // ERROR response on the second word
        wr_addr.delete(); wr_data.delete();
        start(32'h4000, 25'd2);
        beat(8'h80); cyc(1);
        beat(8'h90); cyc(1);
        in_valid = 1'b0;
        chk("t4_w0", out_HADDR, 32'h4000);
        cyc(2);
        chk("t4_next", out_HADDR, 32'h4008);
        in_HRESP  = 2'b01;
        in_HREADY = 1'b0;
        cyc(1);
        chk("t4_err", 32'(out_err), 32'h1);
        chk("t4_idle", 32'(out_HTRANS), 32'h0);
        chk("t4_busy", 32'(out_busy), 32'h0);
        chk("t4_no_done1", 32'(out_done), 32'h0);
        in_HREADY = 1'b1;
        cyc(1);
        in_HRESP = 2'b00;
        chk("t4_no_done2", 32'(out_done), 32'h0);
        cyc(5);
        chk("t4_nwrites", 32'(wr_addr.size()), 32'd2);
        chk("t4_still_idle", 32'(out_HTRANS), 32'h0);
        chk("t4_err_sticky", 32'(out_err), 32'h1);
        wr_addr.delete(); wr_data.delete();
        start(32'h4100, 25'd1);
        chk("t4_err_clr", 32'(out_err), 32'h0);
        beat(8'hC0); cyc(1);
        in_valid = 1'b0;
        wait_done(20, seen);
        chk("t4_redo_done", 32'(seen), 32'h1);
        chk("t4_redo_a0", ga(0), 32'h4100);
        chk("t4_redo_d1", gd(1), 32'h00C3_C4C5);

        // Count zero, then start while busy
        wr_addr.delete(); wr_data.delete();
        start(32'h6000, 25'd0);
        chk("t5_zero_done", 32'(out_done), 32'h1);
        chk("t5_zero_busy", 32'(out_busy), 32'h0);
        cyc(1);
        chk("t5_zero_pulse", 32'(out_done), 32'h0);
        cyc(3);
        chk("t5_zero_nobus", 32'(wr_addr.size()), 32'd0);
        start(32'h6000, 25'd2);
        start(32'h7000, 25'd9);
        beat(8'hD0); cyc(1);
        beat(8'hE0); cyc(1);
        in_valid = 1'b0;
        wait_done(30, seen);
        chk("t5_busy_done", 32'(seen), 32'h1);
        chk("t5_nwrites", 32'(wr_addr.size()), 32'd4);
        chk("t5_a0", ga(0), 32'h6000);
        chk("t5_a3", ga(3), 32'h600C);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
